spi_ctrl_core: RTL and testbench
================================

Name: spi_ctrl_core

Overview:
- Control core of the SPI accelerometer-configuration master.
- Divides the 100 MHz system clock to a 5 MHz SCLK and counts bits and bytes of each frame.
- Sequences three configuration commands, then repeats read frames while power is asserted.
- Drives CS, transfer/receive strobes and the command index; a separate shift register consumes these outputs.

Parameters:
- HALF_DIV, 10, system clocks per SCLK half-period (100 MHz / 20 = 5 MHz).
- BYTE_BITS, 8, bits per byte.

Ports:
- clk  in  1  100 MHz system clock; the only clock; all flops on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- power  in  1  power button level; 1 = run sequence, 0 = idle.
- sclk  out  1  5 MHz serial clock, 50% duty, registered.
- sclk_rise  out  1  one-clk pulse in the cycle sclk goes 0->1.
- sclk_fall  out  1  one-clk pulse in the cycle sclk goes 1->0.
- cs  out  1  chip select, active low.
- transfer  out  1  frame in progress (shift register enabled).
- load  out  1  one-clk pulse requesting the next byte for the shift register.
- receive  out  1  high during read frames.
- data_select  out  2  command index: 0 = read/dummy, 1 = range, 2 = FIFO-off, 3 = measure.
- byte_count  out  2  bytes completed in the current frame.
- done  out  1  byte_count == frame size for data_select.

Behaviour:
- Reset (rst_n=0, async):
  - sclk=0, divider count 0.
  - FSM in IDLE; cs=1; transfer=0; receive=0; data_select=0.
  - bit and byte counters 0; all pulses 0.
- Divider:
  - Counts 0..HALF_DIV-1 continuously while out of reset, independent of power.
  - At terminal count, wraps to 0 and toggles sclk.
  - sclk_rise / sclk_fall are asserted in the same clk cycle that sclk changes.
  - Period is 20 clk cycles; the first rising edge occurs 10 clks after reset release.
- Frame sizes (constant table): select 0 -> 3, select 1 -> 3, select 2 -> 2, select 3 -> 3.
- Counter:
  - 3-bit bit counter increments on sclk_rise while transfer=1.
  - On wrap 7->0, byte_count increments.
  - Both counters are held at 0 while transfer=0.
  - byte_count saturates at the frame size.
  - done is combinational: (byte_count == size[data_select]).
- FSM: transitions evaluated only on sclk_fall cycles, except that power=0 forces IDLE on any clk.
  - IDLE: cs=1, data_select=0. If power=1 -> SEL with data_select=1.
  - SEL: cs=0, transfer=0 for one SCLK period -> XFER; assert load in the entry cycle.
  - XFER: cs=0, transfer=1.
    - load pulses on each sclk_fall where the bit counter is 0 and done=0.
    - When done=1 -> GAP.
  - GAP: cs=1, transfer=0 for one SCLK period.
    - If data_select is 1 or 2, increment data_select and go to SEL.
    - If data_select is 3 or 0, set data_select=0, receive=1, go to SEL.
  - Read frames repeat forever (select 0, 3 bytes); receive stays 1 until IDLE.
- Boundary conditions:
  - power falling mid-frame: next clk forces IDLE, cs=1, transfer=0, counters cleared, receive=0.
  - power re-asserted: the sequence restarts at command 1.
  - done and power=0 in the same cycle: power wins.
  - rst_n asserted mid-frame: all outputs return to reset values immediately, without waiting for a clock.

Decomposition:
- Package spi_ctrl_pkg holds:
  - state enum (IDLE, SEL, XFER, GAP);
  - CMD_READ/RANGE/FIFO/MEAS encodings 0..3;
  - frame-size constant array {3,3,2,3};
  - HALF_DIV default.
- One natural sub-module: spi_sclk_gen (divider plus edge pulses).
- Counters and FSM live in the top.

Test Plan:
- Reset with power=0 for 50 clks -> cs=1, sclk=0, transfer=0, data_select=0; sclk toggles every 10 clks with period 200 ns.
- power=1 -> data_select=1 then cs low; exactly 24 sclk_rise pulses during transfer=1; 3 load pulses; done=1 with byte_count=3; cs high for one SCLK period.
- Continue the sequence:
  - data_select=2 frame shows 16 rises and byte_count reaching 2;
  - data_select=3 frame shows 24 rises;
  - then data_select=0 with receive=1, with 3-byte frames repeating.
- Drop power 5 rises into a frame -> cs=1 and transfer=0 on the next clk; counters 0; re-assert -> data_select=1 again.
- Pulse rst_n low for 3 clks during XFER -> outputs at reset values asynchronously; divider restarts from 0.
- Check load timing: each load is on an sclk_fall with bit counter 0; there is no load after done.

Source files
------------

// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg: shared FSM states, command encodings, frame sizes and defaults
// for the SPI accelerometer-configuration control core.
package spi_ctrl_pkg;

    localparam int DEF_HALF_DIV  = 10;
    localparam int DEF_BYTE_BITS = 8;

    typedef enum logic [1:0] {IDLE, SEL, XFER, GAP} state_t;

    localparam logic [1:0] CMD_READ  = 2'd0;
    localparam logic [1:0] CMD_RANGE = 2'd1;
    localparam logic [1:0] CMD_FIFO  = 2'd2;
    localparam logic [1:0] CMD_MEAS  = 2'd3;

    // Bytes per frame, indexed by command: [3]=meas, [2]=fifo, [1]=range, [0]=read
    localparam logic [3:0][1:0] FRAME_SIZE = {2'd3, 2'd2, 2'd3, 2'd3};

endpackage

// File: rtl/spi_ctrl_if.sv
// spi_ctrl_if: control bundle between the SPI control core and its shift register.
//   power                  : run request into the core
//   sclk/sclk_rise/fall    : serial clock and its one-clk edge pulses
//   cs/transfer/load       : chip select (low), frame active, next-byte request
//   receive/data_select    : read-frame flag and command index
//   byte_count/done        : bytes completed and frame-complete flag
interface spi_ctrl_if;
    logic       power;
    logic       sclk;
    logic       sclk_rise;
    logic       sclk_fall;
    logic       cs;
    logic       transfer;
    logic       load;
    logic       receive;
    logic [1:0] data_select;
    logic [1:0] byte_count;
    logic       done;

    modport master (
        input  power,
        output sclk, sclk_rise, sclk_fall, cs, transfer, load,
               receive, data_select, byte_count, done
    );

    modport slave (
        input  sclk, sclk_rise, sclk_fall, cs, transfer, load,
               receive, data_select, byte_count, done
    );
endinterface

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: free-running SCLK divider with registered edge pulses.
//   clk, rst_n          : system clock, async active-low reset
//   sclk                : divided clock, toggles every HALF_DIV clks
//   sclk_rise/sclk_fall : high in the same cycle sclk changes 0->1 / 1->0
module spi_sclk_gen import spi_ctrl_pkg::*; #(
    parameter int HALF_DIV = DEF_HALF_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic sclk,
    output logic sclk_rise,
    output logic sclk_fall
);

    localparam int CW = HALF_DIV > 1 ? $clog2(HALF_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          tc;

    assign tc = cnt == CW'(HALF_DIV - 1);

    // Pulses are registered alongside sclk so they line up with the new level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            sclk      <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
        end else begin
            cnt       <= tc ? '0 : cnt + 1'b1;
            sclk      <= sclk ^ tc;
            sclk_rise <= tc & ~sclk;
            sclk_fall <= tc & sclk;
        end
    end

endmodule

// File: rtl/spi_ctrl_core.sv
// spi_ctrl_core: SPI configuration master control - sequences range, FIFO-off and
// measure commands, then repeats 3-byte read frames while power is held.
//   clk, rst_n : 100 MHz system clock, async active-low reset
//   bus        : spi_ctrl_if master - power in; sclk, strobes, cs, command index out
module spi_ctrl_core import spi_ctrl_pkg::*; #(
    parameter int HALF_DIV  = DEF_HALF_DIV,
    parameter int BYTE_BITS = DEF_BYTE_BITS
) (
    input  logic       clk,
    input  logic       rst_n,
    spi_ctrl_if.master bus
);

    localparam int BW = $clog2(BYTE_BITS);

    state_t        state_q, state_d;
    logic [1:0]    ds_q, ds_d;
    logic          rcv_q, rcv_d;
    logic          entry_q;
    logic [BW-1:0] bit_cnt;
    logic [1:0]    byte_cnt;
    logic          sclk_rise, sclk_fall;
    logic          done, transfer, byte_end, to_read;

    spi_sclk_gen #(.HALF_DIV(HALF_DIV)) u_sclk (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (bus.sclk),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    assign transfer = state_q == XFER;
    assign done     = byte_cnt == FRAME_SIZE[ds_q];
    assign byte_end = bit_cnt == BW'(BYTE_BITS - 1);
    assign to_read  = ds_q == CMD_MEAS || ds_q == CMD_READ;

    // Clearing on !power as well lets counters reach 0 in the same clk the FSM drops to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
        end else if (!transfer || !bus.power) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
        end else if (sclk_rise) begin
            bit_cnt  <= byte_end ? '0 : bit_cnt + 1'b1;
            byte_cnt <= byte_cnt + {1'b0, byte_end & ~done};
        end
    end

    // entry_q marks the first cycle of SEL, where the first byte is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ds_q    <= CMD_READ;
            rcv_q   <= 1'b0;
            entry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ds_q    <= ds_d;
            rcv_q   <= rcv_d;
            entry_q <= state_d == SEL && state_q != SEL;
        end
    end

    // Transitions only on sclk_fall so SEL and GAP each last exactly one SCLK period.
    always_comb begin
        state_d = state_q;
        ds_d    = ds_q;
        rcv_d   = rcv_q;
        if (!bus.power) begin
            state_d = IDLE;
            ds_d    = CMD_READ;
            rcv_d   = 1'b0;
        end else if (sclk_fall) begin
            case (state_q)
                IDLE: begin
                    state_d = SEL;
                    ds_d    = CMD_RANGE;
                end
                SEL:  state_d = XFER;
                XFER: state_d = done ? GAP : XFER;
                GAP: begin
                    state_d = SEL;
                    ds_d    = ds_q == CMD_RANGE ? CMD_FIFO :
                              ds_q == CMD_FIFO  ? CMD_MEAS : CMD_READ;
                    rcv_d   = rcv_q | to_read;
                end
            endcase
        end
    end

    // Later bytes are requested on the sclk_fall that closes each byte, until the frame is full.
    assign bus.load        = (state_q == SEL && entry_q) ||
                             (transfer && sclk_fall && bit_cnt == '0 && !done);
    assign bus.cs          = !(state_q == SEL || state_q == XFER);
    assign bus.transfer    = transfer;
    assign bus.receive     = rcv_q;
    assign bus.data_select = ds_q;
    assign bus.byte_count  = byte_cnt;
    assign bus.done        = done;
    assign bus.sclk_rise   = sclk_rise;
    assign bus.sclk_fall   = sclk_fall;

endmodule

// File: tb/tb_spi_ctrl_core.sv
// tb_spi_ctrl_core: directed self-checking bench for the SPI control core
module tb_spi_ctrl_core;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    spi_ctrl_if bus();

    spi_ctrl_core dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int rises = 0, loads = 0, maxb = 0, fr = 0, stray = 0;
    bit done_seen = 1'b0;
    bit prev_cs   = 1'b1;
    int sz [4] = '{3, 3, 2, 3};

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clk; samples on the falling edge and keeps per-frame tallies (a frame starts when cs drops).
    task automatic tick;
        @(negedge clk);
        fr = !bus.transfer ? 0 : fr + int'(bus.sclk_rise);
        if (bus.load && !((!bus.cs && !bus.transfer) ||
            (bus.transfer && bus.sclk_fall && fr % 8 == 0 && fr > 0 && fr < 8 * sz[bus.data_select])))
            stray++;
        if (!bus.cs && prev_cs) begin
            rises = 0;
            loads = 0;
            maxb = 0;
            done_seen = 1'b0;
        end
        rises += int'(bus.transfer && bus.sclk_rise);
        loads += int'(bus.load);
        if (int'(bus.byte_count) > maxb) maxb = int'(bus.byte_count);
        done_seen |= bus.transfer && bus.done;
        prev_cs = bus.cs;
    endtask

    task automatic first_rise(input string tag);
        int n = 0;
        while (!bus.sclk && n < 50) begin
            tick;
            n++;
        end
        chk(tag, n, 10);
        chk({tag, "_pulse"}, bus.sclk_rise, 1);
    endtask

    task automatic frame(input int ds, input int rcv, input int nb);
        int n = 0;
        while (bus.cs && n < 200) begin
            tick;
            n++;
        end
        chk("sel_cs", bus.cs, 0);
        chk("sel_ds", bus.data_select, ds);
        chk("sel_rcv", bus.receive, rcv);
        chk("sel_xfer", bus.transfer, 0);
        n = 0;
        while (!bus.transfer && n < 100) begin
            tick;
            n++;
        end
        chk("sel_len", n, 20);
        n = 0;
        while (bus.transfer && n < 2000) begin
            tick;
            n++;
        end
        chk("xfer_len", n, 160 * nb);
        chk("rises", rises, 8 * nb);
        chk("loads", loads, nb);
        chk("max_bytes", maxb, nb);
        chk("done_seen", done_seen, 1);
        n = 0;
        while (bus.cs && n < 100) begin
            tick;
            n++;
        end
        chk("gap_len", n, 20);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.power = 1'b0;
        repeat (3) tick;
        chk("rst_cs", bus.cs, 1);
        chk("rst_sclk", bus.sclk, 0);
        chk("rst_xfer", bus.transfer, 0);
        chk("rst_ds", bus.data_select, 0);
        chk("rst_bc", bus.byte_count, 0);
        chk("rst_load", bus.load, 0);
        chk("rst_rcv", bus.receive, 0);
        chk("rst_rise", bus.sclk_rise, 0);
        rst_n = 1'b1;
        first_rise("first_rise");
        n = 0;
        do begin
            tick;
            n++;
        end while (!bus.sclk_rise && n < 100);
        chk("period", n, 20);
        n = 0;
        while (bus.sclk && n < 50) begin
            tick;
            n++;
        end
        chk("high_time", n, 10);
        chk("fall_pulse", bus.sclk_fall, 1);
        repeat (50) tick;
        chk("idle_cs", bus.cs, 1);
        chk("idle_ds", bus.data_select, 0);
        chk("idle_xfer", bus.transfer, 0);

        bus.power = 1'b1;
        frame(1, 0, 3);
        frame(2, 0, 2);
        frame(3, 0, 3);
        frame(0, 1, 3);
        frame(0, 1, 3);

        n = 0;
        while (!(bus.transfer && fr == 5) && n < 2000) begin
            tick;
            n++;
        end
        chk("drop_reach", fr, 5);
        repeat (3) tick;
        bus.power = 1'b0;
        tick;
        chk("drop_cs", bus.cs, 1);
        chk("drop_xfer", bus.transfer, 0);
        chk("drop_bc", bus.byte_count, 0);
        chk("drop_rcv", bus.receive, 0);
        chk("drop_ds", bus.data_select, 0);
        chk("drop_done", bus.done, 0);
        repeat (30) tick;
        bus.power = 1'b1;
        frame(1, 0, 3);

        n = 0;
        while (!bus.transfer && n < 100) begin
            tick;
            n++;
        end
        repeat (45) tick;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sclk", bus.sclk, 0);
        chk("arst_cs", bus.cs, 1);
        chk("arst_xfer", bus.transfer, 0);
        chk("arst_ds", bus.data_select, 0);
        chk("arst_rcv", bus.receive, 0);
        chk("arst_bc", bus.byte_count, 0);
        chk("arst_fall", bus.sclk_fall, 0);
        repeat (3) tick;
        rst_n = 1'b1;
        first_rise("rerun_rise");

        n = 0;
        while (!(bus.transfer && bus.done) && n < 2000) begin
            tick;
            n++;
        end
        chk("done_reach", bus.done, 1);
        bus.power = 1'b0;
        tick;
        chk("done_pwr_ds", bus.data_select, 0);
        chk("done_pwr_cs", bus.cs, 1);
        chk("done_pwr_bc", bus.byte_count, 0);
        chk("done_pwr_rcv", bus.receive, 0);
        repeat (5) tick;
        chk("stray_load", stray, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
